// File: rtl/bomberman_led_arbiter.sv
// bomberman_led_arbiter: two-player LED flash arbiter with an Avalon-MM
// register slave. One requester at a time owns the LEDs for hold*div
// cycles; otherwise the LEDs show the programmable base pattern.
module bomberman_led_arbiter #(
  parameter logic [15:0] DEFAULT_DIV  = 16'd50000,
  parameter logic [15:0] DEFAULT_HOLD = 16'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [1:0]  req,
  input  logic [7:0]  pattern0,
  input  logic [7:0]  pattern1,
  output logic [1:0]  ack,
  output logic [7:0]  out_port
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  // Architectural and sequencing state
  state_t      state_q,   state_d;
  logic [7:0]  base_q,    base_d;
  logic [15:0] hold_q,    hold_d;
  logic [15:0] div_q,     div_d;
  logic        owner_q,   owner_d;
  logic [1:0]  ack_q,     ack_d;
  logic [7:0]  out_q,     out_d;
  logic [15:0] presc_q,   presc_d;
  logic [15:0] holdcnt_q, holdcnt_d;
  // Divider captured at grant so writes during SHOW only affect later flashes
  logic [15:0] shdiv_q,   shdiv_d;

  logic        bus_wr;
  logic        abort;
  logic [15:0] div_eff;
  logic [15:0] hold_eff;
  logic        tick;
  logic        grant_sel;

  // Upper write-data bits carry no register content
  logic        unused_wdata;
  assign unused_wdata = ^writedata[31:16];

  assign bus_wr   = chipselect && !write_n;
  assign abort    = bus_wr && (address == 2'd3) && writedata[0];
  // A programmed zero behaves as one so SHOW always lasts at least one cycle
  assign div_eff  = (div_q  == 16'd0) ? 16'd1 : div_q;
  assign hold_eff = (hold_q == 16'd0) ? 16'd1 : hold_q;
  assign tick     = (presc_q == (shdiv_q - 16'd1));

  // Round-robin choice: a lone requester wins, a tie goes to the non-owner
  always_comb begin
    grant_sel = 1'b0;
    case (req)
      2'b01:   grant_sel = 1'b0;
      2'b10:   grant_sel = 1'b1;
      2'b11:   grant_sel = ~owner_q;
      default: grant_sel = 1'b0;
    endcase
  end

  // Next-state computation for registers, FSM and counters
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    hold_d    = hold_q;
    div_d     = div_q;
    owner_d   = owner_q;
    ack_d     = 2'b00;
    out_d     = out_q;
    presc_d   = presc_q;
    holdcnt_d = holdcnt_q;
    shdiv_d   = shdiv_q;

    if (bus_wr) begin
      case (address)
        2'd0:    base_d = writedata[7:0];
        2'd1:    hold_d = writedata[15:0];
        2'd2:    div_d  = writedata[15:0];
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        // Base pattern tracks the register including a write this cycle
        out_d = base_d;
        if (req != 2'b00) begin
          state_d   = ST_SHOW;
          owner_d   = grant_sel;
          ack_d     = grant_sel ? 2'b10 : 2'b01;
          out_d     = grant_sel ? pattern1 : pattern0;
          holdcnt_d = hold_eff;
          shdiv_d   = div_eff;
          presc_d   = 16'd0;
        end
      end
      ST_SHOW: begin
        if (abort) begin
          state_d   = ST_IDLE;
          out_d     = base_d;
          presc_d   = 16'd0;
          holdcnt_d = 16'd0;
        end else if (tick) begin
          presc_d   = 16'd0;
          holdcnt_d = holdcnt_q - 16'd1;
          if (holdcnt_q == 16'd1) begin
            state_d = ST_IDLE;
            out_d   = base_d;
          end
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = base_d;
      end
    endcase
  end

  // State registers with asynchronous reset to power-on values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      base_q    <= 8'h00;
      hold_q    <= DEFAULT_HOLD;
      div_q     <= DEFAULT_DIV;
      owner_q   <= 1'b1;
      ack_q     <= 2'b00;
      out_q     <= 8'h00;
      presc_q   <= 16'd0;
      holdcnt_q <= 16'd0;
      shdiv_q   <= 16'd1;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      hold_q    <= hold_d;
      div_q     <= div_d;
      owner_q   <= owner_d;
      ack_q     <= ack_d;
      out_q     <= out_d;
      presc_q   <= presc_d;
      holdcnt_q <= holdcnt_d;
      shdiv_q   <= shdiv_d;
    end
  end

  // Combinational register readback
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata = {24'd0, base_q};
      2'd1: readdata = {16'd0, hold_q};
      2'd2: readdata = {16'd0, div_q};
      2'd3: readdata = {28'd0, req, owner_q, (state_q == ST_SHOW)};
      default: readdata = 32'd0;
    endcase
  end

  assign ack      = ack_q;
  assign out_port = out_q;

endmodule

// File: tb/tb_bomberman_led_arbiter.sv
// Directed bench for bomberman_led_arbiter with DEFAULT_DIV=4, DEFAULT_HOLD=3
// (one flash = 12 cycles). Inputs change and outputs are sampled on negedge.
module tb_bomberman_led_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  req;
  logic [7:0]  pattern0;
  logic [7:0]  pattern1;
  logic [1:0]  ack;
  logic [7:0]  out_port;

  int tests_run;
  int tests_failed;

  bomberman_led_arbiter #(
    .DEFAULT_DIV (16'd4),
    .DEFAULT_HOLD(16'd3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .req       (req),
    .pattern0  (pattern0),
    .pattern1  (pattern1),
    .ack       (ack),
    .out_port  (out_port)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%08h", tag, got);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  logic [31:0] rd;
  logic [1:0]  ack_seen [3];
  int          ack_cyc  [3];
  int          n_acks;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    req        = 2'b00;
    pattern0   = 8'h00;
    pattern1   = 8'h00;

    // Reset state
    @(negedge clk);
    check_eq("rst_out", {24'd0, out_port}, 32'h00);
    check_eq("rst_ack", {30'd0, ack}, 32'h0);
    read_reg(2'd0, rd); check_eq("rst_base", rd, 32'h00);
    read_reg(2'd1, rd); check_eq("rst_hold", rd, 32'd3);
    read_reg(2'd2, rd); check_eq("rst_div", rd, 32'd4);
    read_reg(2'd3, rd); check_eq("rst_status", rd, 32'h2);
    @(negedge clk);
    reset = 1'b0;

    // Single requester 0: 12-cycle flash of 0xA5 then base
    req = 2'b01; pattern0 = 8'hA5;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      check_eq($sformatf("flash_out_%0d", i), {24'd0, out_port}, 32'hA5);
      check_eq($sformatf("flash_ack_%0d", i), {30'd0, ack}, (i == 0) ? 32'h1 : 32'h0);
      if (i == 0) req = 2'b00;
      @(negedge clk);
    end
    check_eq("flash_end_out", {24'd0, out_port}, 32'h00);
    read_reg(2'd3, rd); check_eq("flash_end_status", rd, 32'h0);

    // Both requesting from reset: grants alternate 01,10,01 every 13 cycles
    req = 2'b11; pattern0 = 8'h0F; pattern1 = 8'hF0;
    do_reset();
    n_acks = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ack != 2'b00 && n_acks < 3) begin
        ack_seen[n_acks] = ack;
        ack_cyc[n_acks]  = c;
        n_acks++;
      end
    end
    check_eq("rr_count", n_acks, 3);
    if (n_acks == 3) begin
      check_eq("rr_ack0", {30'd0, ack_seen[0]}, 32'h1);
      check_eq("rr_ack1", {30'd0, ack_seen[1]}, 32'h2);
      check_eq("rr_ack2", {30'd0, ack_seen[2]}, 32'h1);
      check_eq("rr_gap01", ack_cyc[1] - ack_cyc[0], 13);
      check_eq("rr_gap12", ack_cyc[2] - ack_cyc[1], 13);
      check_eq("rr_first", ack_cyc[0], 0);
    end
    req = 2'b00;

    // Base write during SHOW shows only after the flash ends
    do_reset();
    req = 2'b01; pattern0 = 8'h5A;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      check_eq($sformatf("basew_out_%0d", i), {24'd0, out_port}, 32'h5A);
      if (i == 0) req = 2'b00;
      if (i == 2) begin
        address = 2'd0; writedata = 32'h3C; chipselect = 1'b1; write_n = 1'b0;
      end else begin
        chipselect = 1'b0; write_n = 1'b1;
      end
      @(negedge clk);
    end
    check_eq("basew_end_out", {24'd0, out_port}, 32'h3C);
    read_reg(2'd0, rd); check_eq("basew_rd", rd, 32'h3C);

    // Base write in IDLE visible next cycle; abort at third SHOW cycle
    do_reset();
    bus_write(2'd0, 32'h11);
    check_eq("idle_base_out", {24'd0, out_port}, 32'h11);
    req = 2'b10; pattern1 = 8'hC3;
    @(negedge clk);
    check_eq("abort_ack", {30'd0, ack}, 32'h2);
    check_eq("abort_out0", {24'd0, out_port}, 32'hC3);
    req = 2'b00;
    @(negedge clk);
    read_reg(2'd3, rd); check_eq("abort_busy", rd, 32'h3);
    @(negedge clk);
    bus_write(2'd3, 32'h1);
    check_eq("abort_out", {24'd0, out_port}, 32'h11);
    check_eq("abort_ack_lo", {30'd0, ack}, 32'h0);
    read_reg(2'd3, rd); check_eq("abort_status", rd, 32'h2);

    // Abort coinciding with the natural end: one clean return to IDLE
    req = 2'b01; pattern0 = 8'h66;
    @(negedge clk);
    check_eq("endab_ack", {30'd0, ack}, 32'h1);
    req = 2'b00;
    repeat (11) @(negedge clk);
    check_eq("endab_last_out", {24'd0, out_port}, 32'h66);
    bus_write(2'd3, 32'h1);
    check_eq("endab_out", {24'd0, out_port}, 32'h11);
    read_reg(2'd3, rd); check_eq("endab_status", rd, 32'h0);
    @(negedge clk);
    check_eq("endab_out2", {24'd0, out_port}, 32'h11);
    check_eq("endab_ack2", {30'd0, ack}, 32'h0);

    // Abort and tie request in the same IDLE cycle: grant wins, goes to player 1
    req = 2'b11; pattern0 = 8'h01; pattern1 = 8'h02;
    bus_write(2'd3, 32'h1);
    check_eq("abreq_ack", {30'd0, ack}, 32'h2);
    check_eq("abreq_out", {24'd0, out_port}, 32'h02);
    req = 2'b00;
    bus_write(2'd3, 32'h1);
    check_eq("abreq_abort_out", {24'd0, out_port}, 32'h11);

    // Hold=0 and div=0 behave as 1: a single-cycle flash
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'h0);
    read_reg(2'd1, rd); check_eq("zero_hold_rd", rd, 32'h0);
    read_reg(2'd2, rd); check_eq("zero_div_rd", rd, 32'h0);
    req = 2'b10; pattern1 = 8'hFF;
    @(negedge clk);
    check_eq("zero_ack", {30'd0, ack}, 32'h2);
    check_eq("zero_out", {24'd0, out_port}, 32'hFF);
    req = 2'b00;
    @(negedge clk);
    check_eq("zero_end_out", {24'd0, out_port}, 32'h11);
    check_eq("zero_end_ack", {30'd0, ack}, 32'h0);

    // Reset during SHOW clears outputs at once; no ack afterwards
    do_reset();
    req = 2'b01; pattern0 = 8'hA5;
    @(negedge clk);
    check_eq("rmid_ack_pre", {30'd0, ack}, 32'h1);
    reset = 1'b1;
    #1;
    check_eq("rmid_out", {24'd0, out_port}, 32'h00);
    check_eq("rmid_ack", {30'd0, ack}, 32'h0);
    read_reg(2'd3, rd); check_eq("rmid_status", rd, 32'h6);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("rmid_quiet_%0d", i), {22'd0, ack, out_port}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
